// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding, kernel modes and sizing helper for the frame controller
//
// Contents:
//   conv_state_t   controller FSM states (IDLE, STREAM, FLUSH, DONE)
//   MODE_*         kernel select values driven on core_mode
//   cnt_width()    width of the per-frame pixel/advance counters
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } conv_state_t;

    localparam logic [1:0] MODE_SHARPEN = 2'd0;
    localparam logic [1:0] MODE_GAUSS   = 2'd1;
    localparam logic [1:0] MODE_EDGE    = 2'd2;
    localparam logic [1:0] MODE_PASS    = 2'd3;

    // Counters must hold the largest advance number of a frame without wrapping.
    function automatic int cnt_width(input int img_w, input int img_h, input int lat);
        return $clog2(img_w * img_h + lat + 1);
    endfunction

endpackage

// File: rtl/conv_raster_cnt.sv
// rtl/conv_raster_cnt.sv - output raster position tracker producing start/end-of-line/end-of-frame flags
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   clr             return to the cleared (all zero) state
//   load            begin a new frame: index 0, flags describe beat 0
//   step            the current output beat was accepted; move to the next index
//   sof, eol, eof   registered markers describing the beat currently presented
module conv_raster_cnt
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CW         = cnt_width(640, 480, 5)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic step,
    output logic sof,
    output logic eol,
    output logic eof
);

    localparam int              COL_W    = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0]   LAST_IDX = CW'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

    logic [CW-1:0]    idx;
    logic [COL_W-1:0] col;
    logic [CW-1:0]    idx_nxt;
    logic [COL_W-1:0] col_nxt;

    always_comb begin
        idx_nxt = idx + CW'(1);
        col_nxt = (col == LAST_COL) ? '0 : col + COL_W'(1);
    end

    // Flags are computed for the index being moved to, so they change only
    // when a beat is accepted and therefore stay put while the output stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            col <= '0;
            sof <= 1'b0;
            eol <= 1'b0;
            eof <= 1'b0;
        end else if (clr) begin
            idx <= '0;
            col <= '0;
            sof <= 1'b0;
            eol <= 1'b0;
            eof <= 1'b0;
        end else if (load) begin
            idx <= '0;
            col <= '0;
            sof <= 1'b1;
            eol <= (LAST_COL == '0);
            eof <= (LAST_IDX == '0);
        end else if (step) begin
            idx <= idx_nxt;
            col <= col_nxt;
            sof <= 1'b0;
            eol <= (col_nxt == LAST_COL);
            eof <= (idx_nxt == LAST_IDX);
        end
    end

endmodule

// File: rtl/conv_frame_ctrl.sv
// rtl/conv_frame_ctrl.sv - frame sequencer between a raster pixel stream, a pipelined convolution core and an output stream
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   start, abort, mode_cfg   frame start request, synchronous abort, kernel select
//   busy, done               frame in progress, one-cycle completion pulse
//   s_valid/s_ready/s_data   raster input stream
//   core_ce/core_pixel/core_mode/core_pixel_out   convolution core interface
//   m_valid/m_ready/m_data/m_sof/m_eol/m_eof      output stream with raster markers
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int CORE_LAT    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode_cfg,
    output logic                   busy,
    output logic                   done,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_data,
    output logic                   core_ce,
    output logic [PIXEL_WIDTH-1:0] core_pixel,
    output logic [1:0]             core_mode,
    input  logic [PIXEL_WIDTH-1:0] core_pixel_out,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [PIXEL_WIDTH-1:0] m_data,
    output logic                   m_sof,
    output logic                   m_eol,
    output logic                   m_eof
);

    localparam int            NPIX      = IMG_WIDTH * IMG_HEIGHT;
    localparam int            CW        = cnt_width(IMG_WIDTH, IMG_HEIGHT, CORE_LAT);
    localparam logic [CW-1:0] LAST_PIX  = CW'(NPIX - 1);
    localparam logic [CW-1:0] LAT_C     = CW'(CORE_LAT);
    localparam logic [CW-1:0] TOTAL_ADV = CW'(NPIX + CORE_LAT);

    conv_state_t   state;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] adv_cnt;
    logic          out_ok;
    logic          handshake;
    logic          start_ok;

    // The core may only advance when the output register is free or being
    // emptied this cycle, which keeps core_pixel_out stable under a stall.
    assign out_ok    = !m_valid || m_ready;
    assign handshake = m_valid && m_ready;
    assign start_ok  = (state == ST_IDLE) && start;

    always_comb begin
        s_ready    = 1'b0;
        core_ce    = 1'b0;
        core_pixel = '0;
        case (state)
            ST_STREAM: begin
                s_ready    = out_ok;
                core_ce    = s_valid && out_ok;
                core_pixel = s_data;
            end
            ST_FLUSH: begin
                // Zeros are pushed until the last real pixel has left the core.
                core_ce = out_ok && (adv_cnt < TOTAL_ADV);
            end
            default: begin
                s_ready    = 1'b0;
                core_ce    = 1'b0;
                core_pixel = '0;
            end
        endcase
    end

    // The core output is only meaningful while a beat is presented.
    assign m_data = m_valid ? core_pixel_out : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            core_mode <= MODE_SHARPEN;
            in_cnt    <= '0;
            adv_cnt   <= '0;
            m_valid   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else if (abort) begin
            state   <= ST_IDLE;
            in_cnt  <= '0;
            adv_cnt <= '0;
            m_valid <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (core_ce) begin
                adv_cnt <= adv_cnt + CW'(1);
            end
            // Advances 1..CORE_LAT only prime the core; their results are dropped.
            if (core_ce && (adv_cnt >= LAT_C)) begin
                m_valid <= 1'b1;
            end else if (handshake) begin
                m_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        core_mode <= mode_cfg;
                        in_cnt    <= '0;
                        adv_cnt   <= '0;
                        m_valid   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (core_ce) begin
                        in_cnt <= in_cnt + CW'(1);
                        if (in_cnt == LAST_PIX) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (handshake && m_eof) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    conv_raster_cnt #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .CW         (CW)
    ) u_raster (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort),
        .load (start_ok),
        .step (handshake),
        .sof  (m_sof),
        .eol  (m_eol),
        .eof  (m_eof)
    );

endmodule
